// File: rtl/cpu_exc_pkg.sv
// Shared definitions for the commit-point exception controller:
// Cause.ExcCode values, mem_exc bit positions, FSM states, handler vector.
package cpu_exc_pkg;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Bit positions inside mem_exc
  localparam int unsigned EXB_ADEL_IF = 0;
  localparam int unsigned EXB_RI      = 1;
  localparam int unsigned EXB_OV      = 2;
  localparam int unsigned EXB_SYS     = 3;
  localparam int unsigned EXB_BP      = 4;
  localparam int unsigned EXB_ADEL_LD = 5;
  localparam int unsigned EXB_ADES    = 6;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  // Recovery sequencer states; encodings match the legacy design
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  // Source of the BadVaddr value written on an exception
  typedef enum logic [1:0] {
    BADV_KEEP  = 2'd0,
    BADV_PC    = 2'd1,
    BADV_DADDR = 2'd2
  } badv_sel_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Priority encoder: picks the single highest-priority event for the MEM
// instruction. Interrupts first, then exceptions in pipeline order, eret last.
module exc_prio_enc
  import cpu_exc_pkg::*;
(
  input  logic       int_req,
  input  logic [6:0] exc,
  input  logic       eret,
  output logic       take,
  output logic       ret,
  output logic [4:0] code,
  output badv_sel_t  bsel
);

  // Fixed-priority selection; any exception masks eret
  always_comb begin
    take = 1'b0;
    ret  = 1'b0;
    code = '0;
    bsel = BADV_KEEP;
    if (int_req) begin
      take = 1'b1;
      code = EXC_INT;
    end else if (exc[EXB_ADEL_IF]) begin
      take = 1'b1;
      code = EXC_ADEL;
      bsel = BADV_PC;
    end else if (exc[EXB_RI]) begin
      take = 1'b1;
      code = EXC_RI;
    end else if (exc[EXB_OV]) begin
      take = 1'b1;
      code = EXC_OV;
    end else if (exc[EXB_SYS]) begin
      take = 1'b1;
      code = EXC_SYS;
    end else if (exc[EXB_BP]) begin
      take = 1'b1;
      code = EXC_BP;
    end else if (exc[EXB_ADEL_LD]) begin
      take = 1'b1;
      code = EXC_ADEL;
      bsel = BADV_DADDR;
    end else if (exc[EXB_ADES]) begin
      take = 1'b1;
      code = EXC_ADES;
      bsel = BADV_DADDR;
    end else if (eret) begin
      ret = 1'b1;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Commit-point exception/interrupt controller. Detects one event at MEM,
// strobes CP0, then drains memory, flushes the pipeline and redirects fetch.
module exc_ctrl
  import cpu_exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [6:0]  mem_exc,
  input  logic        mem_eret,
  input  logic [31:0] mem_daddr,
  input  logic        mem_busy,
  input  logic        cp0_int,
  input  logic        cp0_exl,
  input  logic [31:0] cp0_epc,
  input  logic [31:0] cp0_badvaddr,
  output logic        exc_take,
  output logic        exc_return,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic [31:0] exc_badvaddr,
  output logic        flush,
  output logic        stall_if,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_load;
  logic [31:0]   target;

  logic          detect;
  logic          enc_take;
  logic          enc_ret;
  logic [4:0]    enc_code;
  badv_sel_t     enc_bsel;
  logic          event_hit;

  assign cnt_load = CW'(FLUSH_CYCLES - 1);

  exc_prio_enc u_prio (
    .int_req (cp0_int & ~cp0_exl),
    .exc     (mem_exc),
    .eret    (mem_eret),
    .take    (enc_take),
    .ret     (enc_ret),
    .code    (enc_code),
    .bsel    (enc_bsel)
  );

  // Detection is gated by rstn so every output reads 0 while reset is held
  assign detect    = rstn && (state == ST_IDLE) && mem_valid;
  assign event_hit = exc_take || exc_return;

  // CP0 update strobes and the values written on an exception
  always_comb begin
    exc_take     = detect & enc_take;
    exc_return   = detect & enc_ret;
    exc_code     = '0;
    exc_epc      = '0;
    exc_bd       = 1'b0;
    exc_badvaddr = '0;
    if (exc_take) begin
      exc_code = enc_code;
      exc_bd   = mem_bd;
      exc_epc  = mem_bd ? (mem_pc - 32'd4) : mem_pc;
      unique case (enc_bsel)
        BADV_PC:    exc_badvaddr = mem_pc;
        BADV_DADDR: exc_badvaddr = mem_daddr;
        default:    exc_badvaddr = cp0_badvaddr;
      endcase
    end
  end

  // Pipeline control derived from the current recovery phase
  always_comb begin
    flush          = 1'b0;
    stall_if       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state)
      ST_IDLE: begin
        flush    = event_hit;
        stall_if = event_hit;
      end
      ST_DRAIN, ST_FLUSH: begin
        flush    = 1'b1;
        stall_if = 1'b1;
      end
      ST_REDIRECT: begin
        stall_if       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
      end
      default: ;
    endcase
  end

  // Recovery sequencer, flush counter and latched redirect target
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      target <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (event_hit) begin
            target <= exc_take ? EXC_VECTOR : cp0_epc;
            cnt    <= cnt_load;
            state  <= mem_busy ? ST_DRAIN : ST_FLUSH;
          end
        end
        ST_DRAIN: begin
          if (!mem_busy) begin
            cnt   <= cnt_load;
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (cnt == '0) state <= ST_REDIRECT;
          else           cnt   <= cnt - 1'b1;
        end
        ST_REDIRECT: begin
          if (redirect_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: expected CP0 strobes and redirect
// targets are queued when an event is driven and compared when they appear.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic [6:0]  mem_exc;
  logic        mem_eret;
  logic [31:0] mem_daddr;
  logic        mem_busy;
  logic        cp0_int;
  logic        cp0_exl;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_badvaddr;
  logic        exc_take;
  logic        exc_return;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        flush;
  logic        stall_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  always #5 clk = ~clk;

  exc_ctrl #(
    .EXC_VECTOR   (32'hBFC00380),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .mem_valid      (mem_valid),
    .mem_pc         (mem_pc),
    .mem_bd         (mem_bd),
    .mem_exc        (mem_exc),
    .mem_eret       (mem_eret),
    .mem_daddr      (mem_daddr),
    .mem_busy       (mem_busy),
    .cp0_int        (cp0_int),
    .cp0_exl        (cp0_exl),
    .cp0_epc        (cp0_epc),
    .cp0_badvaddr   (cp0_badvaddr),
    .exc_take       (exc_take),
    .exc_return     (exc_return),
    .exc_code       (exc_code),
    .exc_epc        (exc_epc),
    .exc_bd         (exc_bd),
    .exc_badvaddr   (exc_badvaddr),
    .flush          (flush),
    .stall_if       (stall_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  localparam logic [6:0]  X_ADEL_IF = 7'h01;
  localparam logic [6:0]  X_RI      = 7'h02;
  localparam logic [6:0]  X_OV      = 7'h04;
  localparam logic [6:0]  X_SYS     = 7'h08;
  localparam logic [6:0]  X_BP      = 7'h10;
  localparam logic [6:0]  X_ADES    = 7'h40;
  localparam logic [31:0] VEC       = 32'hBFC00380;
  localparam logic [71:0] M_ALL     = {72{1'b1}};
  localparam logic [71:0] M_STROBE  = {2'b11, 70'd0};

  typedef struct {
    logic [71:0] v;
    logic [71:0] m;
  } exp_t;

  exp_t        evq[$];
  logic [31:0] rdq[$];
  int          tests = 0;
  int          fails = 0;

  logic [71:0]  ev_got;
  logic [106:0] all_out;
  assign ev_got  = {exc_take, exc_return, exc_code, exc_epc, exc_bd, exc_badvaddr};
  assign all_out = {ev_got, flush, stall_if, redirect_valid, redirect_pc};

  function automatic logic [71:0] pack_ev(input logic take, input logic ret,
                                          input logic [4:0] code, input logic [31:0] epc,
                                          input logic bd, input logic [31:0] badv);
    return {take, ret, code, epc, bd, badv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0;
    mem_pc    = '0;
    mem_bd    = 1'b0;
    mem_exc   = '0;
    mem_eret  = 1'b0;
    mem_daddr = '0;
    mem_busy  = 1'b0;
    cp0_int   = 1'b0;
    cp0_exl   = 1'b0;
  endtask

  // Advance from the event cycle until redirect_valid appears (bounded).
  // mem_busy stays high while the cycle index is below busy_cycles;
  // CP0 values are scrambled every cycle so late sampling would show.
  task automatic run_to_redirect(input int busy_cycles, output int n, output int nf);
    n  = 0;
    nf = 0;
    while (redirect_valid !== 1'b1 && n < 40) begin
      tick();
      mem_valid    = 1'b0;
      mem_exc      = '0;
      mem_eret     = 1'b0;
      cp0_int      = 1'b0;
      mem_busy     = (n + 1 < busy_cycles);
      cp0_epc      = $urandom;
      cp0_badvaddr = $urandom;
      @(negedge clk);
      n++;
      if (flush === 1'b1) nf++;
    end
  endtask

  task automatic check_event(input string name);
    exp_t e;
    @(negedge clk);
    e = evq.pop_front();
    tests++;
    if ((ev_got & e.m) !== e.v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, ev_got & e.m, e.v);
    end
    tests++;
    if ({flush, stall_if, redirect_valid} !== 3'b110) begin
      fails++;
      $display("FAIL %s_ctl: got %b expected 110", name, {flush, stall_if, redirect_valid});
    end
  endtask

  // Run a recovery to the redirect, check its timing and target, then accept it
  task automatic finish_recovery(input string name, input int busy_cycles,
                                 input int exp_n, input int exp_nf);
    int n, nf;
    logic [31:0] pc;
    redirect_ready = 1'b1;
    run_to_redirect(busy_cycles, n, nf);
    pc = rdq.pop_front();
    tests++;
    if (n !== exp_n || nf !== exp_nf || redirect_pc !== pc || flush !== 1'b0 || stall_if !== 1'b1) begin
      fails++;
      $display("FAIL %s_redir: got cyc=%0d flush_cyc=%0d pc=%h fl=%b st=%b expected cyc=%0d flush_cyc=%0d pc=%h fl=0 st=1",
               name, n, nf, redirect_pc, flush, stall_if, exp_n, exp_nf, pc);
    end
    tick();
    @(negedge clk);
    tests++;
    if ({flush, stall_if, redirect_valid, redirect_pc} !== 35'd0) begin
      fails++;
      $display("FAIL %s_idle: got fl=%b st=%b rv=%b pc=%h expected all 0",
               name, flush, stall_if, redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_valid = 1'b1; mem_exc = X_OV; cp0_int = 1'b1;
    redirect_ready = 1'b0; cp0_epc = 32'h1234; cp0_badvaddr = 32'h5678;
    rstn = 1'b0;
    tick(); tick();
    @(negedge clk);
    tests++;
    if (all_out !== 107'd0) begin
      fails++;
      $display("FAIL reset: got %h expected 0", all_out);
    end
    idle_inputs();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_ov();
    tick();
    idle_inputs();
    mem_valid = 1'b1; mem_pc = 32'h0000_1010; mem_exc = X_OV; cp0_badvaddr = 32'hDEAD_0000;
    evq.push_back('{pack_ev(1'b1, 1'b0, 5'd12, 32'h1010, 1'b0, 32'hDEAD_0000), M_ALL});
    rdq.push_back(VEC);
    check_event("ov");
    finish_recovery("ov", 0, 3, 2);
  endtask

  task automatic test_ades_drain();
    tick();
    idle_inputs();
    mem_valid = 1'b1; mem_pc = 32'h2004; mem_bd = 1'b1; mem_daddr = 32'h33;
    mem_exc = X_ADES; mem_busy = 1'b1; cp0_badvaddr = 32'hAAAA_5555;
    evq.push_back('{pack_ev(1'b1, 1'b0, 5'd5, 32'h2000, 1'b1, 32'h33), M_ALL});
    rdq.push_back(VEC);
    check_event("ades");
    finish_recovery("ades", 3, 6, 5);
  endtask

  task automatic test_int_prio();
    tick();
    idle_inputs();
    mem_valid = 1'b1; mem_pc = 32'h400; mem_exc = X_RI; cp0_int = 1'b1; cp0_badvaddr = 32'h0BAD;
    evq.push_back('{pack_ev(1'b1, 1'b0, 5'd0, 32'h400, 1'b0, 32'h0BAD), M_ALL});
    rdq.push_back(VEC);
    check_event("int_wins");
    finish_recovery("int_wins", 0, 3, 2);
    tick();
    idle_inputs();
    mem_valid = 1'b1; mem_pc = 32'h404; mem_exc = X_RI; cp0_int = 1'b1; cp0_exl = 1'b1;
    cp0_badvaddr = 32'h0BAD;
    evq.push_back('{pack_ev(1'b1, 1'b0, 5'd10, 32'h404, 1'b0, 32'h0BAD), M_ALL});
    rdq.push_back(VEC);
    check_event("int_masked");
    finish_recovery("int_masked", 0, 3, 2);
  endtask

  task automatic test_eret();
    tick();
    idle_inputs();
    mem_valid = 1'b1; mem_pc = 32'h8000_0100; mem_eret = 1'b1; cp0_epc = 32'h0040_0020;
    evq.push_back('{pack_ev(1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 32'd0), M_STROBE});
    rdq.push_back(32'h0040_0020);
    check_event("eret");
    finish_recovery("eret", 0, 3, 2);
    tick();
    idle_inputs();
    mem_valid = 1'b1; mem_pc = 32'h700; mem_eret = 1'b1; mem_exc = X_SYS;
    cp0_epc = 32'h0040_0020; cp0_badvaddr = 32'h1111;
    evq.push_back('{pack_ev(1'b1, 1'b0, 5'd8, 32'h700, 1'b0, 32'h1111), M_ALL});
    rdq.push_back(VEC);
    check_event("eret_sys");
    finish_recovery("eret_sys", 0, 3, 2);
  endtask

  task automatic test_redirect_hold();
    int n, nf;
    logic [31:0] pc;
    tick();
    idle_inputs();
    mem_valid = 1'b1; mem_pc = 32'h900; mem_exc = X_OV; cp0_badvaddr = 32'h2222;
    redirect_ready = 1'b0;
    evq.push_back('{pack_ev(1'b1, 1'b0, 5'd12, 32'h900, 1'b0, 32'h2222), M_ALL});
    rdq.push_back(VEC);
    check_event("hold_ev");
    run_to_redirect(0, n, nf);
    pc = rdq.pop_front();
    for (int i = 0; i < 5; i++) begin
      tick();
      mem_valid = 1'b1; mem_pc = 32'hA00 + i; mem_exc = X_OV;
      @(negedge clk);
      tests++;
      if ({redirect_valid, redirect_pc, exc_take, exc_return} !== {1'b1, pc, 2'b00}) begin
        fails++;
        $display("FAIL hold_%0d: got rv=%b pc=%h take=%b ret=%b expected rv=1 pc=%h take=0 ret=0",
                 i, redirect_valid, redirect_pc, exc_take, exc_return, pc);
      end
    end
    tick();
    idle_inputs();
    redirect_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({redirect_valid, redirect_pc} !== {1'b1, pc}) begin
      fails++;
      $display("FAIL hold_accept: got rv=%b pc=%h expected rv=1 pc=%h", redirect_valid, redirect_pc, pc);
    end
    tick();
    @(negedge clk);
    tests++;
    if ({redirect_valid, flush, stall_if} !== 3'b000) begin
      fails++;
      $display("FAIL hold_idle: got %b expected 000", {redirect_valid, flush, stall_if});
    end
  endtask

  task automatic test_no_event();
    tick();
    idle_inputs();
    mem_valid = 1'b0; mem_exc = X_OV; cp0_int = 1'b1;
    @(negedge clk);
    tests++;
    if ({exc_take, exc_return, flush, stall_if} !== 4'b0000) begin
      fails++;
      $display("FAIL no_valid: got %b expected 0000", {exc_take, exc_return, flush, stall_if});
    end
    tick();
    idle_inputs();
    mem_valid = 1'b1; cp0_int = 1'b1; cp0_exl = 1'b1;
    @(negedge clk);
    tests++;
    if ({exc_take, exc_return, flush, stall_if} !== 4'b0000) begin
      fails++;
      $display("FAIL int_exl: got %b expected 0000", {exc_take, exc_return, flush, stall_if});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    tick();
    idle_inputs();
    mem_valid = 1'b1; mem_pc = 32'h0; mem_bd = 1'b1; mem_exc = X_SYS | X_BP; cp0_badvaddr = 32'h3333;
    evq.push_back('{pack_ev(1'b1, 1'b0, 5'd8, 32'hFFFF_FFFC, 1'b1, 32'h3333), M_ALL});
    rdq.push_back(VEC);
    check_event("b2b_sys");
    begin
      int n, nf;
      logic [31:0] pc;
      redirect_ready = 1'b1;
      run_to_redirect(0, n, nf);
      pc = rdq.pop_front();
      tests++;
      if (redirect_pc !== pc) begin
        fails++;
        $display("FAIL b2b_redir: got %h expected %h", redirect_pc, pc);
      end
    end
    tick();
    idle_inputs();
    mem_valid = 1'b1; mem_pc = 32'h5002; mem_daddr = 32'h77; mem_exc = X_ADES | X_ADEL_IF;
    cp0_badvaddr = 32'h4444;
    evq.push_back('{pack_ev(1'b1, 1'b0, 5'd4, 32'h5002, 1'b0, 32'h5002), M_ALL});
    rdq.push_back(VEC);
    check_event("b2b_adel_if");
    finish_recovery("b2b_adel_if", 0, 3, 2);
  endtask

  task automatic test_reset_flush();
    int seen;
    tick();
    idle_inputs();
    mem_valid = 1'b1; mem_pc = 32'hC00; mem_exc = X_OV; cp0_badvaddr = 32'h5555;
    redirect_ready = 1'b1;
    evq.push_back('{pack_ev(1'b1, 1'b0, 5'd12, 32'hC00, 1'b0, 32'h5555), M_ALL});
    check_event("rst_ev");
    tick();
    idle_inputs();
    rstn = 1'b0;
    @(negedge clk);
    tests++;
    if (flush !== 1'b1) begin
      fails++;
      $display("FAIL rst_in_flush: got flush=%b expected 1", flush);
    end
    tick();
    @(negedge clk);
    tests++;
    if (all_out !== 107'd0) begin
      fails++;
      $display("FAIL rst_outputs: got %h expected 0", all_out);
    end
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      if (redirect_valid !== 1'b0 || flush !== 1'b0) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL rst_no_redirect: got %0d active cycles expected 0", seen);
    end
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    redirect_ready = 1'b0;
    cp0_epc = '0;
    cp0_badvaddr = '0;
    test_reset();
    test_ov();
    test_ades_drain();
    test_int_prio();
    test_eret();
    test_redirect_hold();
    test_no_event();
    test_back_to_back();
    test_reset_flush();
    tests++;
    if (evq.size() !== 0 || rdq.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_left: got ev=%0d rd=%0d expected 0 0", evq.size(), rdq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Commit-point exception and interrupt controller for the 5-stage CPU.
- Watches the MEM-stage instruction and picks the highest-priority exception, interrupt or eret.
- Drives the CP0 register file's exception and return update strobes.
- Sequences pipeline recovery: waits for any outstanding data-memory access to drain, flushes the pipeline for a set number of cycles, then redirects fetch to the handler or to EPC through a valid/ready handshake.

Parameters:
- EXC_VECTOR, 32'hBFC00380, handler entry PC.
- FLUSH_CYCLES, 2, cycles the FLUSH state holds flush (≥1).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- mem_valid  in  1  MEM stage holds a real instruction
- mem_pc  in  32  PC of MEM instruction
- mem_bd  in  1  MEM instruction is in a branch delay slot
- mem_exc  in  7  exception flags {AdES,AdEL_ld,Bp,Sys,Ov,RI,AdEL_if}, bit0=AdEL_if
- mem_eret  in  1  MEM instruction is eret
- mem_daddr  in  32  data address of MEM load/store
- mem_busy  in  1  data-memory request outstanding
- cp0_int  in  1  CP0 interrupt pending
- cp0_exl  in  1  CP0 STATUS.EXL
- cp0_epc  in  32  CP0 EPC (return address)
- cp0_badvaddr  in  32  current CP0 BadVaddr
- exc_take  out  1  CP0 exception strobe
- exc_return  out  1  CP0 eret strobe
- exc_code  out  5  Cause.ExcCode
- exc_epc  out  32  EPC to write
- exc_bd  out  1  STATUS/Cause BD bit
- exc_badvaddr  out  32  BadVaddr to write
- flush  out  1  kill IF..MEM contents
- stall_if  out  1  freeze fetch
- redirect_valid  out  1  new PC offered to fetch
- redirect_pc  out  32  target PC
- redirect_ready  in  1  fetch accepts redirect

Behaviour:
- States: IDLE, DRAIN, FLUSH, REDIRECT. All outputs are 0 at reset. Reset returns to IDLE from any state, abandoning redirect and target.
- Event detection applies only in IDLE with mem_valid=1. Priority, highest first:
  - Int (code 0): cp0_int & ~cp0_exl.
  - AdEL_if (4).
  - RI (10).
  - Ov (12).
  - Sys (8).
  - Bp (9).
  - AdEL_ld (4).
  - AdES (5).
  - eret.
- Any exception beats eret on the same instruction.
- Exception cycle (combinational, same cycle):
  - exc_take=1.
  - exc_code per the priority above.
  - exc_bd=mem_bd.
  - exc_epc = mem_bd ? mem_pc-4 : mem_pc (mod 2^32).
  - exc_badvaddr: mem_pc for AdEL_if; mem_daddr for AdEL_ld/AdES; otherwise cp0_badvaddr (unchanged).
  - Target EXC_VECTOR is latched.
- Eret cycle: exc_return=1, exc_take=0. Target is latched as cp0_epc as sampled that cycle, before CP0 updates.
- flush=1 and stall_if=1 in the event cycle.
- Transitions:
  - Event cycle → DRAIN if mem_busy=1, else → FLUSH.
  - DRAIN: flush=1, stall_if=1; → FLUSH the first cycle mem_busy=0.
  - FLUSH: flush=1, stall_if=1; counter loads FLUSH_CYCLES-1 on entry and decrements; → REDIRECT when it reaches 0. Total flush cycles in FLUSH = FLUSH_CYCLES.
  - REDIRECT: redirect_valid=1, redirect_pc=target, stall_if=1, flush=0. Holds until redirect_ready; → IDLE on the cycle valid&ready; redirect_pc stays stable while waiting.
- Strobes: exc_take and exc_return are single-cycle and never asserted outside IDLE. MEM inputs and cp0_int are ignored in DRAIN, FLUSH and REDIRECT; the killed pipeline re-raises them if needed.
- cp0_int rising while cp0_exl=1 is ignored. Handling it after EXL clears is CP0's job.
- mem_valid=0 produces no event, even with cp0_int=1.
- Only one event is handled per recovery. There are back-to-back exceptions only after returning to IDLE.

Decomposition:
- Shared package `cpu_exc_pkg` holds:
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12).
  - mem_exc bit indices.
  - State enum.
  - EXC_VECTOR default.
- Sub-module `exc_prio_enc`: combinational priority encoder mapping {int, mem_exc, eret} to {take, return, code, badvaddr select}.
- The FSM, counter and target register stay in exc_ctrl.

Test Plan:
- Ov at mem_pc=0x0000_1010, bd=0, mem_busy=0 → exc_take=1, code=12, epc=0x1010; flush for 1+2 cycles; redirect_pc=0xBFC00380. With redirect_ready held high, back in IDLE 4 cycles after the event.
- AdES with mem_bd=1, mem_pc=0x2004, mem_daddr=0x33, mem_busy high 3 cycles → code=5, epc=0x2000, bd=1, badvaddr=0x33. Stays in DRAIN 3 cycles, then FLUSH 2 cycles, then REDIRECT.
- cp0_int=1, cp0_exl=0, mem_exc=RI, mem_valid=1 → code=0 (interrupt wins). Repeat with cp0_exl=1 → code=10.
- mem_eret, cp0_epc=0x0040_0020, no exceptions → exc_return=1, exc_take=0. redirect_pc=0x00400020 even if cp0_epc changes next cycle. With eret+Sys together → code=8, no exc_return.
- REDIRECT with redirect_ready low 5 cycles → redirect_valid and redirect_pc stable; a new Ov on MEM meanwhile gives no exc_take.
- rstn low during FLUSH → next cycle IDLE, all outputs 0, no redirect issued.
